// File: rtl/io_cfg_loader.sv
// Serial configuration loader for one I/O tile: shifts in a parity-protected
// bitstream and commits it to the track-select bus only when parity matches.
module io_cfg_loader #(
  parameter int unsigned WS     = 7,
  parameter int unsigned WD     = 6,
  parameter int unsigned WG     = 3,
  parameter int unsigned EXTIN  = 5,
  parameter int unsigned EXTOUT = 2,
  localparam int unsigned CW    = (EXTIN + EXTOUT) * (WS + WD + WG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_in,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [CW-1:0] c,
  output logic          cfg_done,
  output logic          cfg_err
);

  localparam int unsigned CNT_W = $clog2(CW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic [CW-1:0]      c_q, c_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept_c;
  logic               last_c;

  assign accept_c = cfg_valid && cfg_ready;
  // Once CW data bits are in, the next accepted bit is the parity bit.
  assign last_c   = (cnt_q == CNT_W'(CW));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping cfg_en always wins over a same-cycle handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_en) state_d = SHIFT;
      end
      SHIFT: begin
        if (!cfg_en) begin
          state_d = IDLE;
        end else if (accept_c && last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!cfg_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: ready depends on state only
  always_comb begin
    cfg_ready = 1'b0;
    if (state_q == SHIFT) cfg_ready = 1'b1;
  end

  // Datapath next-state: shadow shift, bit counter, running parity, commit
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    c_d     = c_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_en) begin
          shift_d = '0;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg_en && accept_c) begin
          if (!last_c) begin
            shift_d = {cfg_in, shift_q[CW-1:1]};
            par_d   = par_q ^ cfg_in;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if ((par_q ^ cfg_in) == 1'b0) begin
            c_d    = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!cfg_en) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      c_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      c_q     <= c_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign c        = c_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Bench for io_cfg_loader: directed scenarios plus randomized loads, all
// checked every cycle against a queue-based model of the load protocol.
module tb_io_cfg_loader;

  localparam int unsigned CW = (5 + 2) * (7 + 6 + 3);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic          cfg_in;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] c;
  logic          cfg_done;
  logic          cfg_err;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  io_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .cfg_in    (cfg_in),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .c         (c),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a load is "open" while collecting bits; it closes after CW+1 bits.
  bit            m_load = 1'b0;
  bit            m_bits[$];
  logic [CW-1:0] m_c = '0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;

  always @(posedge clk) begin
    bit p;
    if (rst) begin
      m_load = 1'b0;
      m_bits.delete();
      m_c    = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else if (m_load) begin
      if (!cfg_en) begin
        m_load = 1'b0;
        m_bits.delete();
      end else if (cfg_valid) begin
        m_bits.push_back(cfg_in);
        if (m_bits.size() == CW + 1) begin
          p = 1'b0;
          foreach (m_bits[i]) p ^= m_bits[i];
          if (p == 1'b0) begin
            for (int i = 0; i < CW; i++) m_c[i] = m_bits[i];
            m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          m_load = 1'b0;
          m_bits.delete();
        end
      end
    end else if (m_done || m_err) begin
      if (!cfg_en) begin
        m_done = 1'b0;
        m_err  = 1'b0;
      end
    end else if (cfg_en) begin
      m_load = 1'b1;
      m_bits.delete();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", 128'(cfg_ready), 128'(m_load));
      chk("cyc_c",     128'(c),         128'(m_c));
      chk("cyc_done",  128'(cfg_done),  128'(m_done));
      chk("cyc_err",   128'(cfg_err),   128'(m_err));
    end
  end

  // Stimulus tasks are entered and left on a falling edge.
  task automatic start_load();
    cfg_en = 1'b1;
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic stop_load();
    cfg_en = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [CW:0] bits, input int n, input bit alt, output int rc);
    rc = 0;
    for (int i = 0; i < n; i++) begin
      if (alt) begin
        if (cfg_ready) rc++;
        cfg_valid = 1'b0;
        cfg_in = 1'($urandom);
        @(negedge clk);
      end
      if (cfg_ready) rc++;
      cfg_valid = 1'b1;
      cfg_in = bits[i];
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  function automatic logic [CW-1:0] mod3_word();
    logic [CW-1:0] w = '0;
    for (int k = 0; k < CW; k++) w[k] = (k % 3 == 0);
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] good;
    logic [CW-1:0] w2;
    int rc;
    good = mod3_word();
    rst = 1'b1; cfg_en = 1'b0; cfg_in = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_c",     128'(c),         128'(0));
    chk("rst_ready", 128'(cfg_ready), 128'(0));
    chk("rst_done",  128'(cfg_done),  128'(0));
    chk("rst_err",   128'(cfg_err),   128'(0));
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", 128'(cfg_ready), 128'(0));
    end

    // Good load: bit k = (k%3==0), 38 ones, parity 0
    start_load();
    send_bits({1'b0, good}, CW + 1, 1'b0, rc);
    chk("good_c",       128'(c), 128'(good));
    chk("good_pop",     128'($countones(c)), 128'(38));
    chk("single0_sel",  128'(c[0]), 128'(1));
    chk("good_bit1",    128'(c[1]), 128'(0));
    chk("good_bit111",  128'(c[111]), 128'(1));
    chk("good_done",    128'(cfg_done), 128'(1));
    chk("good_err",     128'(cfg_err), 128'(0));
    chk("good_rc",      128'(rc), 128'(113));

    // Bad parity: 112 ones then parity 1
    stop_load();
    start_load();
    send_bits({1'b1, {CW{1'b1}}}, CW + 1, 1'b0, rc);
    chk("bad_err",  128'(cfg_err), 128'(1));
    chk("bad_done", 128'(cfg_done), 128'(0));
    chk("bad_c",    128'(c), 128'(good));
    chk("bad_ready", 128'(cfg_ready), 128'(0));

    // Backpressure: alternate invalid/valid with garbage in the gaps
    stop_load();
    start_load();
    send_bits({1'b0, good}, CW + 1, 1'b1, rc);
    chk("bp_c",    128'(c), 128'(good));
    chk("bp_done", 128'(cfg_done), 128'(1));
    chk("bp_rc",   128'(rc), 128'(226));

    // Abort after 40 bits, with a valid bit on the abort cycle
    w2 = ~good;
    stop_load();
    start_load();
    send_bits({1'b1, {CW{1'b1}}}, 40, 1'b0, rc);
    cfg_en = 1'b0; cfg_valid = 1'b1; cfg_in = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("abort_ready", 128'(cfg_ready), 128'(0));
    chk("abort_c",     128'(c), 128'(good));
    chk("abort_done",  128'(cfg_done), 128'(0));
    chk("abort_err",   128'(cfg_err), 128'(0));
    start_load();
    send_bits({^w2, w2}, CW + 1, 1'b0, rc);
    chk("reload_c",    128'(c), 128'(w2));
    chk("reload_done", 128'(cfg_done), 128'(1));

    // Reset mid-load after 60 bits
    stop_load();
    start_load();
    send_bits({1'b0, good}, 60, 1'b0, rc);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_c",     128'(c), 128'(0));
    chk("mrst_ready", 128'(cfg_ready), 128'(0));
    chk("mrst_done",  128'(cfg_done), 128'(0));
    chk("mrst_err",   128'(cfg_err), 128'(0));
    rst = 1'b0;
    cfg_en = 1'b0;

    // Randomized loads: random data/parity, gaps, rare aborts and resets
    for (int it = 0; it < 30; it++) begin
      repeat (1 + $urandom_range(0, 2)) stop_load();
      start_load();
      for (int cyc = 0; cyc < 500 && cfg_ready; cyc++) begin
        cfg_valid = ($urandom_range(0, 3) != 0);
        cfg_in = 1'($urandom);
        if ($urandom_range(0, 499) == 0) cfg_en = 1'b0;
        if ($urandom_range(0, 1499) == 0) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      cfg_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    stop_load();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
